inst_buffer_mw: RTL
===================

# inst_buffer_mw

Multi-lane instruction buffer between the fetch stage and decode. Fetch pushes up to `IN_LANES` packed instruction entries per cycle (predicted target, PC, instruction word, fetch-exception flag and cause). Decode pops up to `OUT_LANES` oldest entries per cycle in program order. A single shared circular store replaces per-lane FIFOs, so lanes never drift out of order. Adds partial-lane push, partial pop, an occupancy count and a programmable almost-full stall.

## Interface
- `DEPTH`, 16, number of entries; power of two, ≥ 2·max(`IN_LANES`, `OUT_LANES`)
- `IN_LANES`, 2, fetch lanes per cycle
- `OUT_LANES`, 2, decode lanes per cycle
- `ENTRY_W`, 104, entry width: {pred_addr[31:0], pc[31:0], inst[31:0], exc, exc_cause[6:0]}
- `STALL_MARGIN`, `IN_LANES`, stall asserted while free slots < this value
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `flush`  in  1  synchronous discard of all contents
- `push_valid`  in  IN_LANES  per-lane entry valid, any bit pattern
- `push_data`  in  IN_LANES·ENTRY_W  lane i at bits [i·ENTRY_W +: ENTRY_W]
- `pop_ready`  in  OUT_LANES  decode accepts lane i
- `out_valid`  out  OUT_LANES  lane i holds the i-th oldest entry
- `out_data`  out  OUT_LANES·ENTRY_W  entries, oldest in lane 0
- `count`  out  $clog2(DEPTH)+1  current occupancy
- `stall`  out  1  fetch must hold; pushes are not accepted

## Operation
- Storage: `DEPTH` × `ENTRY_W` array. `wr_ptr` and `rd_ptr` are $clog2(DEPTH) bits and wrap modulo `DEPTH`. Occupancy is tracked in `count`.
- Push:
  - When `stall`=0 and `flush`=0, the set bits of `push_valid` are compacted in lane order.
  - The k-th valid lane is written to `wr_ptr+k`.
  - `wr_ptr` and `count` advance by popcount(`push_valid`).
  - Gaps such as `push_valid`=2'b10 are legal: lane 1 lands at `wr_ptr`.
- Push while `stall`=1: the entry is dropped with no state change. Fetch holds data until `stall` clears.
- `stall` = (`DEPTH` − `count`) < `STALL_MARGIN`. It is computed from registered `count` only, with no same-cycle pop credit.
- Pop side:
  - `out_valid[i]` = (`count` > i) and !`flush`.
  - `out_data[i]` = mem[`rd_ptr`+i].
  - Pop amount = length of the leading run of i with `out_valid[i]` & `pop_ready[i]`. Non-prefix ready bits beyond the first gap are ignored.
  - `rd_ptr` advances by the pop amount, and `count` decreases by it.
- Simultaneous push and pop: `count_next` = `count` + pushed − popped.
  - Push writes never alias unread slots, because stall guarantees ≥ `STALL_MARGIN` free slots.
  - A pop never reads a same-cycle write.
- Flush has priority over push and pop. Next cycle `wr_ptr`=`rd_ptr`=0 and `count`=0. Memory contents are not cleared.
- Reset (`rst`=0, asynchronous): pointers 0, `count` 0, `out_valid` 0, `stall` 0. Memory is not reset. `out_data` is undefined while `out_valid`=0.
- `count` arithmetic is width $clog2(DEPTH)+1 and never exceeds `DEPTH`.

## Timing
- Push-to-output latency: an entry pushed in cycle N is visible on `out_valid`/`out_data` in cycle N+1. There is no same-cycle bypass.
- Pop is combinational-accept: ready and valid high at edge N means the entry leaves; the next entry is in lane 0 at N+1.
- `stall`, `count` and `out_valid` are functions of registered state (plus `flush` for `out_valid`). There is no combinational path from `push_valid`/`pop_ready` to `stall`.
- Flush in cycle N: `out_valid`=0 in N. The buffer is empty in N+1 and a push in N+1 is accepted.
- Reset deassertion mid-stream: the first accepted push is in the first rising edge after `rst` returns high.
- Wrap-around: lanes straddling index `DEPTH`−1 → 0 read and write correctly within a single cycle.

## Structure
- Shared package `ib_pkg`:
  - `IB_ENTRY_W`=104
  - field offset constants `IB_PRED_LSB`, `IB_PC_LSB`, `IB_INST_LSB`, `IB_EXC_BIT`, `IB_CAUSE_LSB`
  - packed typedef `ib_entry_t`, reused by the fetch and decode stages
- One sub-module `ib_lane_compact`: prefix popcount of `push_valid` producing per-lane write offsets and the total push count. Parametrised by `IN_LANES`.
- The pop-amount leading-run logic stays inline.

## Test plan
- Reset, then push 2 lanes with pc 0x1C000000/0x1C000004 → next cycle `count`=2, `out_valid`=2'b11, lane 0 pc 0x1C000000.
- Fill to 15 with `DEPTH`=16, `STALL_MARGIN`=2 → `stall`=1. A push while stalled leaves `count`=15. Pop 1 → `stall`=0 next cycle.
- `push_valid`=2'b10 with lane 1 pc 0x20 into an empty buffer → `count`=1, lane 0 shows pc 0x20.
- `count`=3, `pop_ready`=2'b10 → nothing popped. `pop_ready`=2'b01 → `count`=2 and the former lane 1 moves to lane 0.
- Simultaneous push 2 / pop 2 across wrap (`rd_ptr`=15, `wr_ptr`=1) for 20 cycles → order preserved and `count` constant.
- Flush with `count`=8 and a concurrent push → `out_valid`=0 that cycle, `count`=0 next cycle, pushed data absent. Async `rst` pulse mid-stream → `count`=0 immediately.

Source files
------------

// File: rtl/ib_pkg.sv
// Shared instruction-buffer entry layout, used by fetch, the buffer and decode.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ib_pkg;

    localparam int IB_ENTRY_W   = 104;
    // Bit offsets inside a packed entry, MSB first: pred_addr, pc, inst, exc, exc_cause.
    localparam int IB_CAUSE_LSB = 0;
    localparam int IB_EXC_BIT   = 7;
    localparam int IB_INST_LSB  = 8;
    localparam int IB_PC_LSB    = 40;
    localparam int IB_PRED_LSB  = 72;

    typedef struct packed {
        logic [31:0] pred_addr;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [6:0]  exc_cause;
    } ib_entry_t;

endpackage

// File: rtl/ib_lane_compact.sv
// Prefix popcount over fetch lane valids: per-lane write offset plus total push count.
// Latency: purely combinational.
// Backpressure: none; the caller gates the result with its own accept condition.
// Ports: push_valid (per-lane valid) -> lane_offs (offset of lane i at [i*CNT_W +: CNT_W]),
//        push_cnt (popcount of push_valid).
module ib_lane_compact #(
    parameter int IN_LANES = 2,
    parameter int CNT_W    = $clog2(IN_LANES + 1)
) (
    input  logic [IN_LANES-1:0]       push_valid,
    output logic [IN_LANES*CNT_W-1:0] lane_offs,
    output logic [CNT_W-1:0]          push_cnt
);

    logic [CNT_W-1:0] acc;

    // Offset of lane i = number of valid lanes below it, so a gap in
    // push_valid never leaves a hole in the store.
    always_comb begin
        acc       = '0;
        lane_offs = '0;
        for (int i = 0; i < IN_LANES; i++) begin
            lane_offs[i*CNT_W +: CNT_W] = acc;
            acc = acc + CNT_W'(push_valid[i]);
        end
        push_cnt = acc;
    end

endmodule

// File: rtl/inst_buffer_mw.sv
// Multi-lane in-order instruction buffer (fetch -> decode) on one shared circular store.
// Latency: push at edge N is visible on out_valid/out_data after edge N (cycle N+1); no bypass.
// Backpressure: stall from registered count only; pushes while stalled are dropped, pop is a ready prefix.
// Ports: clk, rst (async active-low), flush; push_valid/push_data (fetch lanes);
//        pop_ready/out_valid/out_data (decode lanes, oldest in lane 0); count; stall.
module inst_buffer_mw
    import ib_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int IN_LANES     = 2,
    parameter int OUT_LANES    = 2,
    parameter int ENTRY_W      = IB_ENTRY_W,
    parameter int STALL_MARGIN = IN_LANES
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic [IN_LANES-1:0]           push_valid,
    input  logic [IN_LANES*ENTRY_W-1:0]   push_data,
    input  logic [OUT_LANES-1:0]          pop_ready,
    output logic [OUT_LANES-1:0]          out_valid,
    output logic [OUT_LANES*ENTRY_W-1:0]  out_data,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          stall
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int LCNT_W = $clog2(IN_LANES + 1);
    localparam int OCNT_W = $clog2(OUT_LANES + 1);

    logic [ENTRY_W-1:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]           count_q, count_d;

    logic [IN_LANES*LCNT_W-1:0] lane_offs;
    logic [LCNT_W-1:0]          push_cnt;
    logic [OCNT_W-1:0]          pop_cnt;
    logic                       push_ok;
    logic                       pop_run;

    ib_lane_compact #(
        .IN_LANES (IN_LANES),
        .CNT_W    (LCNT_W)
    ) u_compact (
        .push_valid (push_valid),
        .lane_offs  (lane_offs),
        .push_cnt   (push_cnt)
    );

    // No pop credit in stall: it must not depend on pop_ready in the same cycle.
    assign stall   = (CNT_W'(DEPTH) - count_q) < CNT_W'(STALL_MARGIN);
    assign push_ok = !stall && !flush;
    assign count   = count_q;

    // Read side: lane i shows the i-th oldest entry; the index wraps naturally
    // because the pointer width equals log2(DEPTH).
    always_comb begin
        out_valid = '0;
        out_data  = '0;
        for (int i = 0; i < OUT_LANES; i++) begin
            out_valid[i]                   = (count_q > CNT_W'(i)) && !flush;
            out_data[i*ENTRY_W +: ENTRY_W] = mem_q[rd_ptr_q + PTR_W'(i)];
        end
    end

    // Pop only the leading run of valid&ready lanes so decode stays in order.
    always_comb begin
        pop_cnt = '0;
        pop_run = 1'b1;
        for (int i = 0; i < OUT_LANES; i++) begin
            if (pop_run && out_valid[i] && pop_ready[i]) begin
                pop_cnt = pop_cnt + OCNT_W'(1);
            end else begin
                pop_run = 1'b0;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(push_cnt);
            end
            rd_ptr_d = rd_ptr_q + PTR_W'(pop_cnt);
            count_d  = count_q + (push_ok ? CNT_W'(push_cnt) : CNT_W'(0)) - CNT_W'(pop_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            for (int i = 0; i < IN_LANES; i++) begin
                if (push_valid[i]) begin
                    mem_q[wr_ptr_q + PTR_W'(lane_offs[i*LCNT_W +: LCNT_W])] <= push_data[i*ENTRY_W +: ENTRY_W];
                end
            end
        end
    end

endmodule
